instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_pkg.sv | 66 ++++++
 rtl/instruction_decoder.sv | 40 ++++
 rtl/instruction_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: timing states, opcodes,
// instruction classes, function-select codes and register enable patterns.
package instruction_sequencer_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } timingState_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_BRA,
    CLS_BNE,
    CLS_MOVL,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } instrClass_e;

  localparam logic [5:0] OP_NOP       = 6'h00;
  localparam logic [5:0] OP_BRA       = 6'h01;
  localparam logic [5:0] OP_BNE       = 6'h02;
  localparam logic [5:0] OP_MOVL      = 6'h03;
  localparam logic [5:0] OP_ALU_FIRST = 6'h04;
  localparam logic [5:0] OP_ALU_LAST  = 6'h13;
  localparam logic [5:0] OP_LOAD      = 6'h20;
  localparam logic [5:0] OP_STORE     = 6'h21;

  // Function-select codes shared by the RF and the ARF
  localparam logic [2:0] FUN_HOLD = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;

  // ARF output select codes
  localparam logic [1:0] SEL_PC = 2'd0;
  localparam logic [1:0] SEL_AR = 2'd1;
  localparam logic [1:0] SEL_SP = 2'd2;

  // Active-low register enables; all ones means every register holds.
  // Bit 3 is R1/S1 and bit 0 is R4/S4; for the ARF bit 2 is PC.
  localparam logic [3:0] REG_HOLD     = 4'b1111;
  localparam logic [2:0] ARF_REG_HOLD = 3'b111;
  localparam logic [2:0] ARF_REG_PC   = 3'b011;

  // ALU function map: ALU opcodes 6'h04..6'h13 map onto codes 0..15, code 0 is pass-A
  localparam logic [4:0] ALU_PASS_A = 5'h00;

  localparam logic [1:0] MUXA_ALU = 2'b00;
  localparam logic [1:0] MUXA_MEM = 2'b10;
  localparam logic [1:0] MUXA_IMM = 2'b11;
  localparam logic [1:0] MUXB_IMM = 2'b11;

  function automatic logic [4:0] aluFunSel(input logic [5:0] opcode);
    logic [5:0] offset;
    offset = opcode - OP_ALU_FIRST;
    return offset[4:0];
  endfunction

  function automatic logic [3:0] regEnable(input logic [1:0] index);
    return ~(4'b1000 >> index);
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decoder: classifies the opcode and extracts the operand fields.
module instruction_decoder
  import instruction_sequencer_pkg::*;
(
  input  logic [15:0]  irValue,
  output instrClass_e  instrClass,
  output logic [4:0]   aluFun,
  output logic [2:0]   dst,
  output logic [2:0]   src1,
  output logic [2:0]   src2,
  output logic [1:0]   rx
);

  logic [5:0] opcode;
  logic       unusedBits;

  assign opcode     = irValue[15:10];
  assign dst        = irValue[9:7];
  assign src1       = irValue[6:4];
  assign src2       = irValue[3:1];
  assign rx         = irValue[9:8];
  assign aluFun     = aluFunSel(opcode);
  assign unusedBits = irValue[0];

  // Map each opcode onto its instruction class; anything unlisted is illegal
  always_comb begin
    instrClass = CLS_ILLEGAL;
    case (opcode) inside
      OP_NOP:                     instrClass = CLS_NOP;
      OP_BRA:                     instrClass = CLS_BRA;
      OP_BNE:                     instrClass = CLS_BNE;
      OP_MOVL:                    instrClass = CLS_MOVL;
      [OP_ALU_FIRST:OP_ALU_LAST]: instrClass = CLS_ALU;
      OP_LOAD:                    instrClass = CLS_LOAD;
      OP_STORE:                   instrClass = CLS_STORE;
      default:                    instrClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Four-state timing sequencer (fetch low, fetch high, execute, writeback)
// producing the datapath control word from the state and the IR contents.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] IRValue,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  T,
  output logic        Illegal
);

  timingState_e state;
  timingState_e nextState;
  instrClass_e  instrClass;
  logic [4:0]   aluFun;
  logic [2:0]   dst;
  logic [2:0]   src1;
  logic [2:0]   src2;
  logic [1:0]   rx;
  logic         zeroFlag;
  logic         unusedFlags;

  assign zeroFlag    = Flags[3];
  assign unusedFlags = ^Flags[2:0];
  assign T           = {1'b0, state};

  instruction_decoder decoder (
    .irValue    (IRValue),
    .instrClass (instrClass),
    .aluFun     (aluFun),
    .dst        (dst),
    .src1       (src1),
    .src2       (src2),
    .rx         (rx)
  );

  // State register; reset returns to T0 from any state
  always_ff @(posedge Clock) begin
    if (Reset) state <= T0;
    else       state <= nextState;
  end

  // Advance one timing state per cycle, with the writeback state only for LOAD
  always_comb begin
    nextState = state;
    unique case (state)
      T0: if (Run) nextState = T1;
      T1: nextState = T2;
      T2: nextState = (instrClass == CLS_LOAD) ? T3 : T0;
      T3: nextState = T0;
    endcase
  end

  // Control word: idle by default, fetch in T0/T1, per-class execute in T2, LOAD writeback in T3
  always_comb begin
    RF_OutASel  = 3'd0;
    RF_OutBSel  = 3'd0;
    RF_FunSel   = FUN_HOLD;
    RF_RegSel   = REG_HOLD;
    RF_ScrSel   = REG_HOLD;
    ALU_FunSel  = 5'd0;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'd0;
    ARF_OutDSel = 2'd0;
    ARF_FunSel  = FUN_HOLD;
    ARF_RegSel  = ARF_REG_HOLD;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'd0;
    MuxBSel     = 2'd0;
    MuxCSel     = 1'b0;
    Illegal     = 1'b0;
    if (!Reset) begin
      unique case (state)
        T0: begin
          if (Run) begin
            ARF_OutDSel = SEL_PC;
            Mem_CS      = 1'b0;
            IR_Write    = 1'b1;
            IR_LH       = 1'b0;
            ARF_RegSel  = ARF_REG_PC;
            ARF_FunSel  = FUN_INC;
          end
        end
        T1: begin
          ARF_OutDSel = SEL_PC;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = 1'b1;
          ARF_RegSel  = ARF_REG_PC;
          ARF_FunSel  = FUN_INC;
        end
        T2: begin
          case (instrClass)
            CLS_BRA: begin
              ARF_RegSel = ARF_REG_PC;
              ARF_FunSel = FUN_LOAD;
              MuxBSel    = MUXB_IMM;
            end
            CLS_BNE: begin
              if (!zeroFlag) begin
                ARF_RegSel = ARF_REG_PC;
                ARF_FunSel = FUN_LOAD;
                MuxBSel    = MUXB_IMM;
              end
            end
            CLS_MOVL: begin
              MuxASel   = MUXA_IMM;
              RF_FunSel = FUN_LOAD;
              RF_RegSel = regEnable(rx);
            end
            CLS_ALU: begin
              ALU_FunSel = aluFun;
              ALU_WF     = 1'b1;
              RF_OutASel = src1;
              RF_OutBSel = src2;
              MuxASel    = MUXA_ALU;
              RF_FunSel  = FUN_LOAD;
              if (dst[2]) RF_ScrSel = regEnable(dst[1:0]);
              else        RF_RegSel = regEnable(dst[1:0]);
            end
            CLS_LOAD: begin
              ARF_OutDSel = SEL_AR;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b0;
            end
            CLS_STORE: begin
              RF_OutASel  = {1'b0, rx};
              ALU_FunSel  = ALU_PASS_A;
              ALU_WF      = 1'b0;
              MuxCSel     = 1'b0;
              ARF_OutDSel = SEL_AR;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            CLS_ILLEGAL: Illegal = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          ARF_OutDSel = SEL_AR;
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b0;
          MuxASel     = MUXA_MEM;
          RF_FunSel   = FUN_LOAD;
          RF_RegSel   = regEnable(rx);
        end
      endcase
    end
  end

endmodule
